// File: rtl/l2_req_arbiter_if.sv
// Signal bundle around l2_req_arbiter: I-cache and D-cache request/response ports plus the L2 processor-side port.
interface l2_req_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              ic_read;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_ready;

    logic              dc_read;
    logic              dc_write;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_ready;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [DATA_W-1:0] l2_wdata;
    logic [DATA_W-1:0] l2_rdata;
    logic              l2_ready;

    // slave is the arbiter; master is everything around it (both L1s and the L2).
    modport slave (
        input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, l2_rdata, l2_ready,
        output ic_rdata, ic_ready, dc_rdata, dc_ready, l2_read, l2_write, l2_addr, l2_wdata
    );

    modport master (
        output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, l2_rdata, l2_ready,
        input  ic_rdata, ic_ready, dc_rdata, dc_ready, l2_read, l2_write, l2_addr, l2_wdata
    );
endinterface

// File: rtl/l2_req_arbiter.sv
// Merges I-cache and D-cache line requests onto the single L2 processor port, one transaction at a time.
// Optional L2ARB_DFIRST_EN: fixed D-over-I priority on ties instead of round-robin.
module l2_req_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic            clk,
    input  logic            proc_reset_n,
    l2_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

    state_t            state;
    state_t            state_nxt;
    side_t             owner;
    side_t             last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_write_q;
    logic [DATA_W-1:0] ic_rdata_q;
    logic [DATA_W-1:0] dc_rdata_q;

    logic ic_req;
    logic dc_req;
    logic grant_i;
    logic grant_d;

    // Simultaneous dc_read and dc_write is illegal and counts as no D request.
    assign ic_req = bus.ic_read;
    assign dc_req = bus.dc_read ^ bus.dc_write;

`ifdef L2ARB_DFIRST_EN
    assign grant_d = dc_req;
`else
    assign grant_d = dc_req && (!ic_req || (last_grant == SIDE_I));
`endif
    assign grant_i = ic_req && !grant_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no branch leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (grant_i || grant_d) state_nxt = BUSY;
            BUSY:    if (bus.l2_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            owner      <= SIDE_I;
            last_grant <= SIDE_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            if (state == IDLE && grant_d) begin
                owner      <= SIDE_D;
                last_grant <= SIDE_D;
                addr_q     <= bus.dc_addr;
                wdata_q    <= bus.dc_wdata;
                op_write_q <= bus.dc_write;
            end else if (state == IDLE && grant_i) begin
                owner      <= SIDE_I;
                last_grant <= SIDE_I;
                addr_q     <= bus.ic_addr;
                op_write_q <= 1'b0;
            end
            // A D write completion leaves dc_rdata holding the last read line.
            if (state == BUSY && bus.l2_ready) begin
                if (owner == SIDE_I) begin
                    ic_rdata_q <= bus.l2_rdata;
                end else if (!op_write_q) begin
                    dc_rdata_q <= bus.l2_rdata;
                end
            end
        end
    end

    always_comb begin
        bus.l2_read  = (state == BUSY) && !op_write_q;
        bus.l2_write = (state == BUSY) && op_write_q;
        bus.ic_ready = (state == RESP) && (owner == SIDE_I);
        bus.dc_ready = (state == RESP) && (owner == SIDE_D);
    end

    assign bus.l2_addr  = addr_q;
    assign bus.l2_wdata = wdata_q;
    assign bus.ic_rdata = ic_rdata_q;
    assign bus.dc_rdata = dc_rdata_q;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Randomized scoreboard bench for l2_req_arbiter: a transaction-timeline model predicts grants, L2 traffic and ready pulses.
module tb_l2_req_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] line_t;
    typedef enum int {K_RD, K_WR, K_BAD} kind_e;
    typedef struct {
        kind_e kind;
        addr_t addr;
        line_t wdata;
        int    lat;
        int    gap;
    } item_t;
    typedef struct {
        int    cyc;
        line_t data;
    } resp_t;

    logic clk = 1'b0;
    logic proc_reset_n = 1'b0;

    l2_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    l2_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .proc_reset_n(proc_reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Requester agents.
    item_t iq[$];
    item_t dq[$];
    item_t i_cur;
    item_t d_cur;
    bit    i_act = 1'b0, d_act = 1'b0, i_gnt = 1'b0, d_gnt = 1'b0;
    int    i_done = 0, d_done = 0, i_wait = 0, d_wait = 0, d_bad_left = 0;

    // Reference timeline: one L2 transaction occupies [bf, bt], owner ready at bt+1, next decision at bt+2.
    bit    last_d = 1'b0;
    int    next_free = 0;
    int    bf = -1, bt = -1;
    bit    b_wr = 1'b0;
    addr_t resp_addr = '0;
    addr_t e_addr_prev = '0, e_addr_new = '0;
    line_t e_wd_prev = '0, e_wd_new = '0;
    int    e_from = 0;
    line_t dc_last = '0;
    resp_t ic_exp[$];
    resp_t dc_exp[$];

    task automatic check(input string name, input line_t act, input line_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic line_t line_of(input addr_t a);
        logic [31:0] w;
        w = {4'h0, a};
        return {32'hDEADBEEF, w ^ 32'hC0DE_0000, ~w, w * 32'd3};
    endfunction

    function automatic line_t rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_i();
        if (i_act && i_gnt && cyc > i_done) i_act = 1'b0;
        if (!i_act && iq.size() > 0) begin
            if (i_wait < iq[0].gap) begin
                i_wait++;
            end else begin
                i_cur  = iq.pop_front();
                i_act  = 1'b1;
                i_gnt  = 1'b0;
                i_wait = 0;
            end
        end
        bus.ic_read = i_act;
        bus.ic_addr = (i_act && !i_gnt) ? i_cur.addr : addr_t'($urandom);
    endtask

    task automatic drive_d();
        if (d_act && d_cur.kind == K_BAD) begin
            if (d_bad_left == 0) d_act = 1'b0;
            else d_bad_left--;
        end else if (d_act && d_gnt && cyc > d_done) begin
            d_act = 1'b0;
        end
        if (!d_act && dq.size() > 0) begin
            if (d_wait < dq[0].gap) begin
                d_wait++;
            end else begin
                d_cur      = dq.pop_front();
                d_act      = 1'b1;
                d_gnt      = 1'b0;
                d_wait     = 0;
                d_bad_left = d_cur.lat;
            end
        end
        bus.dc_read  = d_act && (d_cur.kind != K_WR);
        bus.dc_write = d_act && (d_cur.kind != K_RD);
        bus.dc_addr  = (d_act && !d_gnt) ? d_cur.addr : addr_t'($urandom);
        bus.dc_wdata = (d_act && !d_gnt) ? d_cur.wdata : rnd_line();
    endtask

    // Decide the winner for this cycle from the requests the agents are presenting.
    task automatic arbitrate();
        bit    iv, dv, take_d, wr;
        int    lat;
        addr_t a;
        line_t d;
        if (cyc < next_free) return;
        iv = i_act && !i_gnt;
        dv = d_act && !d_gnt && (d_cur.kind != K_BAD);
        if (!iv && !dv) return;
        if (iv && dv) begin
`ifdef L2ARB_DFIRST_EN
            take_d = 1'b1;
`else
            take_d = !last_d;
`endif
        end else begin
            take_d = dv;
        end
        e_addr_prev = e_addr_new;
        e_wd_prev   = e_wd_new;
        if (take_d) begin
            lat    = d_cur.lat;
            a      = d_cur.addr;
            wr     = (d_cur.kind == K_WR);
            d_gnt  = 1'b1;
            d_done = cyc + 2 + lat;
            if (!wr) dc_last = line_of(a);
            d = dc_last;
            dc_exp.push_back('{d_done, d});
            e_wd_new = d_cur.wdata;
            last_d = 1'b1;
        end else begin
            lat    = i_cur.lat;
            a      = i_cur.addr;
            wr     = 1'b0;
            i_gnt  = 1'b1;
            i_done = cyc + 2 + lat;
            ic_exp.push_back('{i_done, line_of(a)});
            last_d = 1'b0;
        end
        e_addr_new = a;
        e_from     = cyc + 1;
        bf         = cyc + 1;
        bt         = cyc + 1 + lat;
        b_wr       = wr;
        resp_addr  = a;
        next_free  = cyc + 3 + lat;
    endtask

    // L2 model: stray l2_ready outside a transaction must be ignored by the arbiter.
    task automatic respond();
        if (cyc == bt) begin
            bus.l2_ready = 1'b1;
            bus.l2_rdata = b_wr ? rnd_line() : line_of(resp_addr);
        end else if (cyc >= bf && cyc < bt) begin
            bus.l2_ready = 1'b0;
            bus.l2_rdata = rnd_line();
        end else begin
            bus.l2_ready = ($urandom_range(0, 3) == 0);
            bus.l2_rdata = rnd_line();
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive_i();
        drive_d();
        arbitrate();
        respond();
    endtask

    task automatic monitor();
        bit    in_txn, exp_i, exp_d;
        resp_t r;
        in_txn = (cyc >= bf) && (cyc <= bt);
        check("l2_read_write", {bus.l2_read, bus.l2_write}, {in_txn && !b_wr, in_txn && b_wr});
        check("l2_addr", bus.l2_addr, (cyc >= e_from) ? e_addr_new : e_addr_prev);
        check("l2_wdata", bus.l2_wdata, (cyc >= e_from) ? e_wd_new : e_wd_prev);
        exp_i = (ic_exp.size() > 0) && (ic_exp[0].cyc == cyc);
        exp_d = (dc_exp.size() > 0) && (dc_exp[0].cyc == cyc);
        check("ic_ready", bus.ic_ready, exp_i);
        check("dc_ready", bus.dc_ready, exp_d);
        if (exp_i) begin
            r = ic_exp.pop_front();
            check("ic_rdata", bus.ic_rdata, r.data);
        end
        if (exp_d) begin
            r = dc_exp.pop_front();
            check("dc_rdata", bus.dc_rdata, r.data);
        end
    endtask

    always @(negedge clk) if (mon_en) monitor();

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || i_act || d_act || ic_exp.size() > 0 ||
                dc_exp.size() > 0 || cyc < next_free) && n < limit) begin
            step();
            n++;
        end
        check("drain_within_budget", line_t'(n < limit), line_t'(1));
    endtask

    initial begin
        item_t it;
        bus.ic_read  = 1'b0;
        bus.ic_addr  = '0;
        bus.dc_read  = 1'b0;
        bus.dc_write = 1'b0;
        bus.dc_addr  = '0;
        bus.dc_wdata = '0;
        bus.l2_ready = 1'b0;
        bus.l2_rdata = '0;

        // Reset values, then a D write interrupted by an asynchronous reset.
        repeat (2) @(posedge clk);
        #3 proc_reset_n = 1'b1;
        @(posedge clk); cyc++; #1;
        check("rst_l2_rw", {bus.l2_read, bus.l2_write}, 0);
        check("rst_ready", {bus.ic_ready, bus.dc_ready}, 0);
        check("rst_l2_addr", bus.l2_addr, 0);
        check("rst_l2_wdata", bus.l2_wdata, 0);
        check("rst_ic_rdata", bus.ic_rdata, 0);
        check("rst_dc_rdata", bus.dc_rdata, 0);
        bus.dc_write = 1'b1;
        bus.dc_addr  = 28'h0000010;
        bus.dc_wdata = {16{8'hA5}};
        @(posedge clk); cyc++; #1;
        check("busy_l2_write", {bus.l2_read, bus.l2_write}, 2'b01);
        check("busy_l2_addr", bus.l2_addr, 28'h0000010);
        check("busy_l2_wdata", bus.l2_wdata, {16{8'hA5}});
        @(posedge clk); cyc++; #1;
        check("busy_hold_write", {bus.l2_read, bus.l2_write}, 2'b01);
        #2 proc_reset_n = 1'b0;
        #1;
        check("async_rst_l2_rw", {bus.l2_read, bus.l2_write}, 0);
        check("async_rst_ready", {bus.ic_ready, bus.dc_ready}, 0);
        check("async_rst_l2_addr", bus.l2_addr, 0);
        bus.dc_write = 1'b0;
        @(posedge clk); cyc++; #1;
        proc_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); cyc++; #1;
            check("post_rst_no_reissue", {bus.l2_read, bus.l2_write, bus.ic_ready, bus.dc_ready}, 0);
        end

        next_free = cyc;
        mon_en    = 1'b1;

        // Tie straight after reset (D first), then a second tie to show alternation.
        iq.push_back('{K_RD, addr_t'(28'h0000040), line_t'(0), 0, 0});
        dq.push_back('{K_RD, addr_t'(28'h0000080), line_t'(0), 0, 0});
        iq.push_back('{K_RD, addr_t'(28'h0000041), line_t'(0), 1, 0});
        dq.push_back('{K_RD, addr_t'(28'h0000081), line_t'(0), 2, 0});
        drain(200);
        iq.push_back('{K_RD, addr_t'(28'h0000123), line_t'(0), 0, 0});
        drain(200);
        dq.push_back('{K_WR, addr_t'(28'h0000005), {16{8'hA5}}, 7, 0});
        drain(200);
        dq.push_back('{K_BAD, addr_t'(28'h0000033), line_t'(0), 10, 0});
        drain(200);
        iq.push_back('{K_RD, addr_t'(28'h0000010), line_t'(0), 0, 0});
        iq.push_back('{K_RD, addr_t'(28'h0000011), line_t'(0), 0, 0});
        drain(200);

        for (int k = 0; k < 240; k++) begin
            it.addr  = addr_t'($urandom);
            it.wdata = rnd_line();
            it.lat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 2));
            it.gap   = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                it.kind = K_RD;
                iq.push_back(it);
            end else begin
                case ($urandom_range(0, 9))
                    0:          it.kind = K_BAD;
                    1, 2, 3, 4: it.kind = K_WR;
                    default:    it.kind = K_RD;
                endcase
                dq.push_back(it);
            end
        end
        drain(20000);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
